ascii_to_lower_stream: RTL and testbench
========================================

Name: ascii_to_lower_stream

Overview:
Streaming ASCII lowercase converter. It is the inverse of the team's combinational uppercase converter. It accepts bytes on a valid/ready input, converts 'A'..'Z' to 'a'..'z', and buffers results in a small FIFO that drives a valid/ready output. It also keeps saturating statistics counters. It sits between a character source (UART RX, keyboard scanner) and a downstream consumer that may stall.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16.
CNT_W, 16, width of statistics counters.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  ascii_in holds a byte.
in_ready  output  1  block can accept a byte this cycle.
ascii_in  input  8  input character.
out_valid  output  1  ascii_out holds a converted byte.
out_ready  input  1  consumer takes ascii_out this cycle.
ascii_out  output  8  converted character (head of FIFO).
clear_counts  input  1  synchronous clear of both counters.
byte_count  output  CNT_W  bytes accepted since reset/clear, saturating.
conv_count  output  CNT_W  bytes actually changed (uppercase letters), saturating.

Behaviour:
- Clock is clk; reset is asynchronous, active-low rst_n.
- While rst_n=0, all of the following hold immediately, independent of clk:
  - FIFO is emptied: read pointer, write pointer and occupancy are 0.
  - out_valid=0.
  - ascii_out=8'h00.
  - in_ready=0.
  - byte_count=0 and conv_count=0.
- On the first clk edge after rst_n deasserts, in_ready rises to 1.
- Conversion is a pure function applied at write time:
  - If 8'h41 <= ascii_in <= 8'h5A, the stored value is ascii_in | 8'h20.
  - All other values, including 8'h80..8'hFF, digits, punctuation and lowercase letters, pass unchanged.
  - Only bit 5 of an uppercase letter is ever modified.
- Input handshake: a byte is accepted on a rising edge where in_valid && in_ready.
  - in_ready = rst released && (occupancy < DEPTH).
  - in_ready depends only on registered occupancy, never on out_ready, so there is no combinational in-to-out path.
- Output handshake: the head byte is popped on a rising edge where out_valid && out_ready.
  - out_valid = (occupancy != 0).
  - ascii_out = FIFO[rd_ptr].
  - ascii_out equals 8'h00 when the FIFO is empty.
  - ascii_out is stable while out_valid && !out_ready.
- Latency: a byte accepted at edge N shows out_valid=1 with that byte after edge N, i.e. in cycle N+1. There is no bypass.
- Ordering is strict FIFO order.
- Simultaneous push and pop in the same cycle: occupancy is unchanged and both pointers advance.
  - Allowed at any occupancy from 1 to DEPTH-1.
  - When full, in_ready=0, so only the pop occurs.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.
- Counters:
  - byte_count increments by 1 on every accepted input byte.
  - conv_count increments by 1 on every accepted byte in 8'h41..8'h5A.
  - Both saturate at 2^CNT_W-1 and do not wrap.
  - If clear_counts=1 on an edge, both counters become 0 on that edge and the increment for a byte accepted on the same edge is discarded. Clear wins.
- Reset mid-stream: any buffered bytes are lost. There is no partial output, and out_valid drops asynchronously with rst_n.
- A byte presented with in_valid=1 while in_ready=0 is not consumed. The source must hold it.

Test Plan:
- Reset/idle: assert rst_n=0 mid-simulation with 2 bytes buffered -> out_valid=0, ascii_out=8'h00, in_ready=0 and counters 0 immediately. in_ready=1 one edge after release.
- Conversion sweep, out_ready=1: feed 8'h00..8'hFF one per cycle -> output stream equals input except 8'h41..8'h5A map to 8'h61..8'h7A. byte_count=256, conv_count=26, each output 1 cycle after acceptance.
- Backpressure/full: out_ready=0, feed "HELLO" -> "H","E","L","L" accepted (DEPTH=4) and in_ready=0 holding 'O'. Then out_ready=1 -> output "hello" in order, with 'O' accepted the cycle after the first pop.
- Simultaneous push/pop: with occupancy 2, hold in_valid=out_ready=1 for 10 cycles -> occupancy stays 2, no loss or duplication, pointers wrap correctly.
- Counter clear and saturation: with CNT_W=4, send 20 'A' bytes -> byte_count=conv_count=15, held. Assert clear_counts on the same edge a 'Z' is accepted -> both counters 0 and 'z' still emitted.
- Non-letter boundaries: send 8'h40 '@', 8'h5B '[', 8'h60 '`', 8'h7B '{', 8'hC1 -> all output unchanged, conv_count unchanged.

Source files
------------

// File: rtl/ascii_to_lower_stream.sv
// rtl/ascii_to_lower_stream.sv - streaming ASCII lowercase converter with output FIFO and stats
// Bytes are converted on write; the FIFO head drives the output handshake.
module ascii_to_lower_stream #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       ascii_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       ascii_out,
  input  logic             clear_counts,
  output logic [CNT_W-1:0] byte_count,
  output logic [CNT_W-1:0] conv_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]      L_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]      L_OCC_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]    L_PTR_ONE = AW'(1);
  localparam logic [CNT_W-1:0] L_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] L_CNT_ONE = CNT_W'(1);

  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_occ;
  logic             r_live;
  logic [CNT_W-1:0] r_byte_count;
  logic [CNT_W-1:0] r_conv_count;

  logic             w_push;
  logic             w_pop;
  logic             w_is_upper;
  logic [7:0]       w_wdata;

  assign w_is_upper = (ascii_in >= 8'h41) && (ascii_in <= 8'h5A);
  assign w_wdata    = w_is_upper ? (ascii_in | 8'h20) : ascii_in;

  // in_ready comes only from registered state, so no comb path from out_ready
  assign in_ready   = r_live && (r_occ < L_FULL);
  assign out_valid  = (r_occ != '0);
  assign ascii_out  = out_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign byte_count = r_byte_count;
  assign conv_count = r_conv_count;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + L_OCC_ONE;
      end else if (w_pop && !w_push) begin
        r_occ <= r_occ - L_OCC_ONE;
      end
    end
  end

  // clear takes priority over a same-edge increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_count <= '0;
      r_conv_count <= '0;
    end else if (clear_counts) begin
      r_byte_count <= '0;
      r_conv_count <= '0;
    end else if (w_push) begin
      if (r_byte_count != L_CNT_MAX) begin
        r_byte_count <= r_byte_count + L_CNT_ONE;
      end
      if (w_is_upper && (r_conv_count != L_CNT_MAX)) begin
        r_conv_count <= r_conv_count + L_CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_ascii_to_lower_stream.sv
// tb/tb_ascii_to_lower_stream.sv - directed self-checking bench for ascii_to_lower_stream
module tb_ascii_to_lower_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  ascii_in;
  logic        out_ready;
  logic        clear_counts;

  logic        in_ready, out_valid;
  logic [7:0]  ascii_out;
  logic [15:0] byte_count, conv_count;

  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_ascii_out;
  logic [3:0]  s_byte_count, s_conv_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ascii_to_lower_stream #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ascii_in(ascii_in), .out_valid(out_valid), .out_ready(out_ready),
    .ascii_out(ascii_out), .clear_counts(clear_counts),
    .byte_count(byte_count), .conv_count(conv_count)
  );

  ascii_to_lower_stream #(.DEPTH(4), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .ascii_in(ascii_in), .out_valid(s_out_valid), .out_ready(out_ready),
    .ascii_out(s_ascii_out), .clear_counts(clear_counts),
    .byte_count(s_byte_count), .conv_count(s_conv_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic ordy, input logic clr);
    @(negedge clk);
    in_valid     = v;
    ascii_in     = d;
    out_ready    = ordy;
    clear_counts = clr;
  endtask

  function automatic logic [7:0] lower(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hello [5];
    logic [7:0] seq [12];
    logic [7:0] nl [5];
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    nl    = '{8'h40, 8'h5B, 8'h60, 8'h7B, 8'hC1};

    rst_n = 1'b0; in_valid = 1'b0; ascii_in = 8'h00; out_ready = 1'b0; clear_counts = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ascii_out", 32'(ascii_out), 32'h00);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_byte_count", 32'(byte_count), 32'd0);
    rst_n = 1'b1;
    #1 check("rel_in_ready_pre", 32'(in_ready), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("rel_in_ready_post", 32'(in_ready), 32'd1);

    // full byte sweep, consumer always ready
    for (int k = 0; k < 256; k++) begin
      step(1'b1, 8'(k), 1'b1, 1'b0);
      check("sweep_in_ready", 32'(in_ready), 32'd1);
      if (k > 0) begin
        check("sweep_valid", 32'(out_valid), 32'd1);
        check("sweep_data", 32'(ascii_out), 32'(lower(8'(k - 1))));
      end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("sweep_last", 32'(ascii_out), 32'hFF);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("sweep_empty_valid", 32'(out_valid), 32'd0);
    check("sweep_empty_data", 32'(ascii_out), 32'h00);
    check("sweep_byte_count", 32'(byte_count), 32'd256);
    check("sweep_conv_count", 32'(conv_count), 32'd26);
    check("sweep_small_byte_sat", 32'(s_byte_count), 32'd15);
    check("sweep_small_conv_sat", 32'(s_conv_count), 32'd15);

    // backpressure: DEPTH=4 fills with HELL, O waits
    for (int i = 0; i < 4; i++) begin
      step(1'b1, hello[i], 1'b0, 1'b0);
      check("bp_in_ready", 32'(in_ready), 32'd1);
    end
    step(1'b1, hello[4], 1'b0, 1'b0);
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    check("bp_head", 32'(ascii_out), 32'h68);
    step(1'b1, hello[4], 1'b1, 1'b0);
    check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    check("bp_hold_head", 32'(ascii_out), 32'h68);
    step(1'b1, hello[4], 1'b1, 1'b0);
    check("bp_after_pop_ready", 32'(in_ready), 32'd1);
    check("bp_e", 32'(ascii_out), 32'h65);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("bp_l1", 32'(ascii_out), 32'h6C);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("bp_l2", 32'(ascii_out), 32'h6C);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("bp_o", 32'(ascii_out), 32'h6F);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("bp_empty", 32'(out_valid), 32'd0);
    check("bp_byte_count", 32'(byte_count), 32'd261);
    check("bp_conv_count", 32'(conv_count), 32'd31);

    // simultaneous push/pop at occupancy 2
    seq[0] = 8'h61; seq[1] = 8'h62;
    for (int i = 0; i < 10; i++) seq[i + 2] = 8'(8'h30 + i);
    step(1'b1, 8'h61, 1'b0, 1'b0);
    step(1'b1, 8'h62, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
      check("pp_in_ready", 32'(in_ready), 32'd1);
      check("pp_data", 32'(ascii_out), 32'(seq[i]));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pp_drain0", 32'(ascii_out), 32'(seq[10]));
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pp_drain1", 32'(ascii_out), 32'(seq[11]));
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pp_empty", 32'(out_valid), 32'd0);

    // clear then saturate the 4-bit counters with 20 'A'
    step(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'h41, 1'b1, 1'b0);
      if (i > 0) check("sat_data", 32'(s_ascii_out), 32'h61);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("sat_byte", 32'(s_byte_count), 32'd15);
    check("sat_conv", 32'(s_conv_count), 32'd15);
    check("sat_wide_byte", 32'(byte_count), 32'd20);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("sat_byte_held", 32'(s_byte_count), 32'd15);
    step(1'b1, 8'h5A, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("clr_byte", 32'(s_byte_count), 32'd0);
    check("clr_conv", 32'(s_conv_count), 32'd0);
    check("clr_wide_byte", 32'(byte_count), 32'd0);
    check("clr_valid", 32'(out_valid), 32'd1);
    check("clr_data", 32'(ascii_out), 32'h7A);

    // non-letter boundaries
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, nl[i], 1'b1, 1'b0);
      if (i > 0) check("nl_data", 32'(ascii_out), 32'(nl[i - 1]));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("nl_last", 32'(ascii_out), 32'hC1);
    check("nl_conv", 32'(conv_count), 32'd0);
    check("nl_byte", 32'(byte_count), 32'd5);

    // reset mid-stream with two buffered bytes
    step(1'b1, 8'h51, 1'b0, 1'b0);
    step(1'b1, 8'h52, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_ascii_out", 32'(ascii_out), 32'h00);
    check("mid_in_ready", 32'(in_ready), 32'd0);
    check("mid_byte_count", 32'(byte_count), 32'd0);
    check("mid_conv_count", 32'(conv_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid_rel_pre", 32'(in_ready), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("mid_rel_post", 32'(in_ready), 32'd1);
    check("mid_rel_empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
